// File: rtl/ip_header_builder.sv
// IPv4 header generator: streams a 20..60 byte header into the TX RAM one byte
// per cycle, then back-fills the internally computed header checksum.
module ip_header_builder #(
    parameter int unsigned HDR_OFFSET    = 14,
    parameter int unsigned ADDR_W        = 10,
    parameter logic [31:0] SRC_IP        = 32'hC0A80001,
    parameter logic [7:0]  TTL           = 8'd64,
    parameter int unsigned MAX_OPT_WORDS = 4
) (
    input  logic              iDm9000aClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [15:0]       iTotalLen,
    input  logic [15:0]       iIpId,
    input  logic [7:0]        iTos,
    input  logic              iDf,
    input  logic [7:0]        iProto,
    input  logic [31:0]       iDstIp,
    input  logic [3:0]        iOptWords,
    output logic              oWren,
    output logic [ADDR_W-1:0] oAddr,
    output logic [7:0]        oData,
    output logic              oBusy,
    output logic              oDone,
    output logic [15:0]       oChecksum
);

    typedef enum logic [2:0] {IDLE, WRITE, FOLD1, FOLD2, CK_HI, CK_LO, DONE} state_t;

    localparam logic [3:0]        MAX_N   = 4'(MAX_OPT_WORDS);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(HDR_OFFSET);
    localparam logic [ADDR_W-1:0] CK_ADDR = ADDR_W'(HDR_OFFSET + 10);

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d, len_q;
    logic [3:0]        ihl_q;
    logic [15:0]       tot_q, id_q;
    logic [7:0]        tos_q, proto_q;
    logic              df_q;
    logic [31:0]       dst_q;
    logic [31:0]       acc_q, acc_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       ck_q, ck_d, cks_q, cks_d;
    logic              wren_q, wren_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    logic [3:0]  n_in, ihl_in;
    logic [7:0]  byte_c;
    logic [31:0] fold_c;
    logic [15:0] ck_c;

    assign n_in   = (iOptWords > MAX_N) ? MAX_N : iOptWords;
    assign ihl_in = 4'd5 + n_in;
    assign fold_c = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
    assign ck_c   = ~fold_c[15:0];

    // Bytes 10/11 and all option bytes read as zero, so they add nothing to the sum.
    always_comb begin
        byte_c = 8'h00;
        case (cnt_q)
            6'd0:  byte_c = {4'h4, ihl_q};
            6'd1:  byte_c = tos_q;
            6'd2:  byte_c = tot_q[15:8];
            6'd3:  byte_c = tot_q[7:0];
            6'd4:  byte_c = id_q[15:8];
            6'd5:  byte_c = id_q[7:0];
            6'd6:  byte_c = {1'b0, df_q, 6'b0};
            6'd8:  byte_c = TTL;
            6'd9:  byte_c = proto_q;
            6'd12: byte_c = SRC_IP[31:24];
            6'd13: byte_c = SRC_IP[23:16];
            6'd14: byte_c = SRC_IP[15:8];
            6'd15: byte_c = SRC_IP[7:0];
            6'd16: byte_c = dst_q[31:24];
            6'd17: byte_c = dst_q[23:16];
            6'd18: byte_c = dst_q[15:8];
            6'd19: byte_c = dst_q[7:0];
            default: byte_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        ck_d    = ck_q;
        cks_d   = cks_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (iStart) begin
                // Byte 0 goes out on the start edge, straight from the live inputs.
                state_d = WRITE;
                cnt_d   = 6'd1;
                acc_d   = 32'h0;
                hi_d    = {4'h4, ihl_in};
                wren_d  = 1'b1;
                addr_d  = BASE;
                data_d  = {4'h4, ihl_in};
            end
            WRITE: if (cnt_q == len_q) begin
                state_d = FOLD1;
            end else begin
                wren_d = 1'b1;
                addr_d = BASE + ADDR_W'(cnt_q);
                data_d = byte_c;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q[0]) acc_d = acc_q + {16'h0, hi_q, byte_c};
                else          hi_d  = byte_c;
            end
            FOLD1: begin
                acc_d   = fold_c;
                state_d = FOLD2;
            end
            FOLD2: begin
                acc_d   = fold_c;
                ck_d    = ck_c;
                wren_d  = 1'b1;
                addr_d  = CK_ADDR;
                data_d  = ck_c[15:8];
                state_d = CK_HI;
            end
            CK_HI: begin
                wren_d  = 1'b1;
                addr_d  = CK_ADDR + ADDR_W'(1);
                data_d  = ck_q[7:0];
                cks_d   = ck_q;
                state_d = CK_LO;
            end
            CK_LO: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            ck_q    <= '0;
            cks_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            ihl_q   <= '0;
            tot_q   <= '0;
            id_q    <= '0;
            tos_q   <= '0;
            df_q    <= 1'b0;
            proto_q <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            ck_q    <= ck_d;
            cks_q   <= cks_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (state_q == IDLE && iStart) begin
                len_q   <= 6'd20 + {n_in, 2'b00};
                ihl_q   <= ihl_in;
                tot_q   <= iTotalLen;
                id_q    <= iIpId;
                tos_q   <= iTos;
                df_q    <= iDf;
                proto_q <= iProto;
                dst_q   <= iDstIp;
            end
        end
    end

    assign oWren     = wren_q;
    assign oAddr     = addr_q;
    assign oData     = data_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oChecksum = cks_q;

endmodule
